// File: rtl/ara_tohost_ctrl.sv
// HTIF-style tohost/fromhost mailbox on AXI4-Lite, producing the harness exit word
// {code, done} with an optional watchdog that forces a failing exit on hang.
module ara_tohost_ctrl #(
  parameter int unsigned AddrWidth     = 64,
  parameter logic [63:0] BaseAddr      = 64'h8000_1000,
  parameter int unsigned TimeoutCycles = 0,
  parameter logic [63:0] TimeoutCode   = 64'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [63:0]          w_data_i,
  input  logic [7:0]           w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [63:0]          r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [63:0]          exit_o
);

  localparam logic [AddrWidth-1:0] Base       = AddrWidth'(BaseAddr);
  localparam logic [31:0]          TimeoutLim = TimeoutCycles;
  localparam logic [1:0]           RespOkay   = 2'b00;
  localparam logic [1:0]           RespSlvErr = 2'b10;

  typedef enum logic [1:0] {SelToHost, SelFromHost, SelNone} sel_e;

  // Word index relative to the base; the byte offset within a word is ignored.
  function automatic sel_e decode(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] word;
    word = (addr - Base) >> 3;
    if (word == '0) return SelToHost;
    else if (word == AddrWidth'(1)) return SelFromHost;
    else return SelNone;
  endfunction

  logic                 awFull_q, awFull_d;
  logic [AddrWidth-1:0] awAddr_q, awAddr_d;
  logic                 wFull_q, wFull_d;
  logic [63:0]          wData_q, wData_d;
  logic [7:0]           wStrb_q, wStrb_d;
  logic                 bValid_q, bValid_d;
  logic [1:0]           bResp_q, bResp_d;
  logic                 rValid_q, rValid_d;
  logic [63:0]          rData_q, rData_d;
  logic [1:0]           rResp_q, rResp_d;
  logic                 awReady_q, awReady_d;
  logic                 wReady_q, wReady_d;
  logic                 arReady_q, arReady_d;
  logic [63:0]          toHost_q, toHost_d;
  logic [63:0]          fromHost_q, fromHost_d;
  logic [63:0]          exit_q, exit_d;
  logic [31:0]          wdCnt_q, wdCnt_d;

  logic        update;
  logic        done;
  sel_e        wrSel;
  sel_e        rdSel;
  logic [63:0] oldVal;
  logic [63:0] merged;

  always_comb begin
    awFull_d   = awFull_q;
    awAddr_d   = awAddr_q;
    wFull_d    = wFull_q;
    wData_d    = wData_q;
    wStrb_d    = wStrb_q;
    bValid_d   = bValid_q;
    bResp_d    = bResp_q;
    rValid_d   = rValid_q;
    rData_d    = rData_q;
    rResp_d    = rResp_q;
    toHost_d   = toHost_q;
    fromHost_d = fromHost_q;
    exit_d     = exit_q;
    wdCnt_d    = wdCnt_q;
    done       = exit_q[0];
    update     = awFull_q && wFull_q;
    wrSel      = decode(awAddr_q);
    rdSel      = decode(ar_addr_i);
    oldVal     = (wrSel == SelToHost) ? toHost_q : fromHost_q;
    merged     = oldVal;
    for (int i = 0; i < 8; i++) begin
      if (wStrb_q[i]) merged[8*i +: 8] = wData_q[8*i +: 8];
    end

    if (bValid_q && b_ready_i) bValid_d = 1'b0;
    if (aw_valid_i && awReady_q) begin
      awFull_d = 1'b1;
      awAddr_d = aw_addr_i;
    end
    if (w_valid_i && wReady_q) begin
      wFull_d = 1'b1;
      wData_d = w_data_i;
      wStrb_d = w_strb_i;
    end

    if (TimeoutCycles != 0 && !done) begin
      if (wdCnt_q != TimeoutLim) wdCnt_d = wdCnt_q + 32'd1;
      if (wdCnt_d == TimeoutLim) exit_d = {TimeoutCode[62:0], 1'b1};
    end

    // The program exit is applied after the watchdog so it wins a same-cycle tie.
    if (update) begin
      awFull_d = 1'b0;
      wFull_d  = 1'b0;
      bValid_d = 1'b1;
      bResp_d  = (wrSel == SelNone) ? RespSlvErr : RespOkay;
      if (wrSel == SelToHost) begin
        toHost_d = merged;
        if (merged[0] && !done) exit_d = merged;
      end else if (wrSel == SelFromHost) begin
        fromHost_d = merged;
      end
    end

    if (rValid_q && r_ready_i) rValid_d = 1'b0;
    if (ar_valid_i && arReady_q) begin
      rValid_d = 1'b1;
      case (rdSel)
        SelToHost:   begin rData_d = toHost_q;   rResp_d = RespOkay;   end
        SelFromHost: begin rData_d = fromHost_q; rResp_d = RespOkay;   end
        default:     begin rData_d = 64'd0;      rResp_d = RespSlvErr; end
      endcase
    end

    awReady_d = !awFull_d && !bValid_d;
    wReady_d  = !wFull_d && !bValid_d;
    arReady_d = !rValid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awFull_q   <= 1'b0;
      awAddr_q   <= '0;
      wFull_q    <= 1'b0;
      wData_q    <= 64'd0;
      wStrb_q    <= 8'd0;
      bValid_q   <= 1'b0;
      bResp_q    <= 2'b00;
      rValid_q   <= 1'b0;
      rData_q    <= 64'd0;
      rResp_q    <= 2'b00;
      awReady_q  <= 1'b0;
      wReady_q   <= 1'b0;
      arReady_q  <= 1'b0;
      toHost_q   <= 64'd0;
      fromHost_q <= 64'd0;
      exit_q     <= 64'd0;
      wdCnt_q    <= 32'd0;
    end else begin
      awFull_q   <= awFull_d;
      awAddr_q   <= awAddr_d;
      wFull_q    <= wFull_d;
      wData_q    <= wData_d;
      wStrb_q    <= wStrb_d;
      bValid_q   <= bValid_d;
      bResp_q    <= bResp_d;
      rValid_q   <= rValid_d;
      rData_q    <= rData_d;
      rResp_q    <= rResp_d;
      awReady_q  <= awReady_d;
      wReady_q   <= wReady_d;
      arReady_q  <= arReady_d;
      toHost_q   <= toHost_d;
      fromHost_q <= fromHost_d;
      exit_q     <= exit_d;
      wdCnt_q    <= wdCnt_d;
    end
  end

  assign aw_ready_o = awReady_q;
  assign w_ready_o  = wReady_q;
  assign b_valid_o  = bValid_q;
  assign b_resp_o   = bResp_q;
  assign ar_ready_o = arReady_q;
  assign r_valid_o  = rValid_q;
  assign r_data_o   = rData_q;
  assign r_resp_o   = rResp_q;
  assign exit_o     = exit_q;

endmodule

// File: tb/tb_ara_tohost_ctrl.sv
// Directed bench for ara_tohost_ctrl: one instance without watchdog, one with a
// 50-cycle watchdog, both driven by the same bus stimulus.
module tb_ara_tohost_ctrl;

  localparam logic [63:0] BASE = 64'h8000_1000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] aw_addr_i = '0;
  logic        aw_valid_i = 1'b0;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        w_valid_i = 1'b0;
  logic        b_ready_i = 1'b0;
  logic [63:0] ar_addr_i = '0;
  logic        ar_valid_i = 1'b0;
  logic        r_ready_i = 1'b0;

  logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic [63:0] r_data_o, exit_o;

  logic        wdAwReady, wdWReady, wdBValid, wdArReady, wdRValid;
  logic [1:0]  wdBResp, wdRResp;
  logic [63:0] wdRData, wdExit;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ara_tohost_ctrl #(.AddrWidth(64), .BaseAddr(BASE), .TimeoutCycles(0), .TimeoutCode(64'hFFFF)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .exit_o(exit_o)
  );

  ara_tohost_ctrl #(.AddrWidth(64), .BaseAddr(BASE), .TimeoutCycles(50), .TimeoutCode(64'hFFFF)) dutWd (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(wdAwReady),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(wdWReady),
    .b_resp_o(wdBResp), .b_valid_o(wdBValid), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(wdArReady),
    .r_data_o(wdRData), .r_resp_o(wdRResp), .r_valid_o(wdRValid), .r_ready_i(r_ready_i),
    .exit_o(wdExit)
  );

  // Reset with release on a falling edge; returns just after the first counted rising edge.
  task automatic applyReset();
    rst_ni = 1'b0;
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    b_ready_i = 1'b0; r_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Offers AW and/or W until each is accepted, dropping each valid right after its handshake.
  task automatic sendWrite(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input bit doAw, input bit doW);
    bit awDone, wDone, awHit, wHit;
    awDone = !doAw;
    wDone  = !doW;
    aw_addr_i = addr;
    w_data_i  = data;
    w_strb_i  = strb;
    for (int cyc = 0; cyc < 20 && !(awDone && wDone); cyc++) begin
      aw_valid_i = !awDone;
      w_valid_i  = !wDone;
      awHit = aw_valid_i && aw_ready_o;
      wHit  = w_valid_i && w_ready_o;
      @(posedge clk_i);
      #1;
      if (awHit) awDone = 1'b1;
      if (wHit) wDone = 1'b1;
    end
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    checks++;
    if (!(awDone && wDone)) begin
      errors++;
      $display("[TB] FAIL write_handshake addr=%h aw_done=%0b w_done=%0b expected both 1", addr, awDone, wDone);
    end
  endtask

  task automatic waitB(output logic [1:0] resp);
    int cyc;
    cyc = 0;
    while (!b_valid_o && cyc < 20) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    checks++;
    if (!b_valid_o) begin
      errors++;
      $display("[TB] FAIL b_timeout b_valid=%0b expected 1", b_valid_o);
    end
    resp = b_resp_o;
  endtask

  task automatic ackB();
    b_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    b_ready_i = 1'b0;
  endtask

  task automatic readReg(input logic [63:0] addr, output logic [63:0] data, output logic [1:0] resp);
    bit hit, accepted;
    accepted = 1'b0;
    ar_addr_i = addr;
    ar_valid_i = 1'b1;
    for (int cyc = 0; cyc < 20 && !accepted; cyc++) begin
      hit = ar_ready_o;
      @(posedge clk_i);
      #1;
      if (hit) accepted = 1'b1;
    end
    ar_valid_i = 1'b0;
    checks++;
    if (!accepted || !r_valid_o) begin
      errors++;
      $display("[TB] FAIL read_handshake addr=%h accepted=%0b r_valid=%0b expected 1/1", addr, accepted, r_valid_o);
    end
    data = r_data_o;
    resp = r_resp_o;
    r_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    r_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks++;
    if ({aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake got=%b expected 00000",
               {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o});
    end
    checks++;
    if ({b_resp_o, r_resp_o} !== 4'b0 || r_data_o !== 64'd0 || exit_o !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_data resp=%b r_data=%h exit=%h expected zeros", {b_resp_o, r_resp_o}, r_data_o, exit_o);
    end
    applyReset();
    checks++;
    if ({aw_ready_o, w_ready_o, ar_ready_o} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b expected 111", {aw_ready_o, w_ready_o, ar_ready_o});
    end
  endtask

  task automatic test_pass_exit();
    applyReset();
    sendWrite(BASE, 64'h1, 8'hFF, 1'b1, 1'b1);
    checks++;
    if (b_valid_o !== 1'b0 || exit_o !== 64'd0) begin
      errors++;
      $display("[TB] FAIL pass_early b_valid=%0b exit=%h expected 0/0", b_valid_o, exit_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (b_valid_o !== 1'b1 || b_resp_o !== 2'b00 || exit_o !== 64'h1) begin
      errors++;
      $display("[TB] FAIL pass_b b_valid=%0b resp=%b exit=%h expected 1/00/1", b_valid_o, b_resp_o, exit_o);
    end
    ackB();
    repeat (100) @(posedge clk_i);
    #1;
    checks++;
    if (exit_o !== 64'h1) begin
      errors++;
      $display("[TB] FAIL pass_sticky exit=%h expected 1", exit_o);
    end
  endtask

  task automatic test_split_exit();
    logic [63:0] data;
    logic [1:0]  resp;
    applyReset();
    sendWrite(BASE, 64'h7, 8'hFF, 1'b0, 1'b1);
    repeat (2) begin
      checks++;
      if (w_ready_o !== 1'b0 || b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL split_wait w_ready=%0b b_valid=%0b aw_ready=%0b expected 0/0/1",
                 w_ready_o, b_valid_o, aw_ready_o);
      end
      @(posedge clk_i);
      #1;
    end
    sendWrite(BASE, 64'h7, 8'hFF, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    checks++;
    if (b_valid_o !== 1'b1 || b_resp_o !== 2'b00 || exit_o !== 64'h7) begin
      errors++;
      $display("[TB] FAIL split_b b_valid=%0b resp=%b exit=%h expected 1/00/7", b_valid_o, b_resp_o, exit_o);
    end
    ackB();
    checks++;
    if (b_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL split_single_b b_valid=%0b expected 0", b_valid_o);
    end
    sendWrite(BASE, 64'h1, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    ackB();
    checks++;
    if (exit_o !== 64'h7) begin
      errors++;
      $display("[TB] FAIL split_sticky exit=%h expected 7", exit_o);
    end
    readReg(BASE, data, resp);
    checks++;
    if (data !== 64'h1 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL split_readback data=%h resp=%b expected 1/00", data, resp);
    end
  endtask

  task automatic test_strobes();
    logic [63:0] data;
    logic [1:0]  resp;
    applyReset();
    sendWrite(BASE + 64'd8, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    ackB();
    sendWrite(BASE + 64'd8, 64'h5555, 8'h03, 1'b1, 1'b1);
    waitB(resp);
    ackB();
    readReg(BASE + 64'd8, data, resp);
    checks++;
    if (data !== 64'hAAAA_AAAA_AAAA_5555 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL strobe_merge data=%h resp=%b expected aaaaaaaaaaaa5555/00", data, resp);
    end
    checks++;
    if (exit_o !== 64'd0) begin
      errors++;
      $display("[TB] FAIL strobe_exit exit=%h expected 0", exit_o);
    end
  endtask

  task automatic test_decode_backpressure();
    logic [63:0] data;
    logic [1:0]  resp;
    applyReset();
    sendWrite(BASE + 64'd8, 64'h1234, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    ackB();
    sendWrite(BASE + 64'd16, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("[TB] FAIL decode_bresp resp=%b expected 10", resp);
    end
    repeat (5) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (b_valid_o !== 1'b1 || b_resp_o !== 2'b10 || aw_ready_o !== 1'b0 || w_ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure b_valid=%0b resp=%b aw_ready=%0b w_ready=%0b expected 1/10/0/0",
                 b_valid_o, b_resp_o, aw_ready_o, w_ready_o);
      end
    end
    ackB();
    readReg(BASE + 64'd8, data, resp);
    checks++;
    if (data !== 64'h1234 || exit_o !== 64'd0) begin
      errors++;
      $display("[TB] FAIL decode_no_update fromhost=%h exit=%h expected 1234/0", data, exit_o);
    end
    readReg(BASE + 64'd16, data, resp);
    checks++;
    if (data !== 64'd0 || resp !== 2'b10) begin
      errors++;
      $display("[TB] FAIL decode_read data=%h resp=%b expected 0/10", data, resp);
    end
  endtask

  task automatic test_watchdog();
    logic [1:0] resp;
    applyReset();
    rst_ni = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (49) @(posedge clk_i);
    #1;
    checks++;
    if (wdExit !== 64'd0) begin
      errors++;
      $display("[TB] FAIL wd_early exit=%h expected 0", wdExit);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (wdExit !== 64'h1FFFF) begin
      errors++;
      $display("[TB] FAIL wd_expire exit=%h expected 1ffff", wdExit);
    end
    repeat (10) @(posedge clk_i);
    #1;
    checks++;
    if (exit_o !== 64'd0) begin
      errors++;
      $display("[TB] FAIL wd_disabled exit=%h expected 0", exit_o);
    end

    rst_ni = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (18) @(posedge clk_i);
    #1;
    sendWrite(BASE, 64'h1, 8'hFF, 1'b1, 1'b1);
    @(posedge clk_i);
    #1;
    checks++;
    if (wdBValid !== 1'b1 || wdExit !== 64'h1) begin
      errors++;
      $display("[TB] FAIL wd_prog_exit b_valid=%0b exit=%h expected 1/1", wdBValid, wdExit);
    end
    ackB();
    repeat (40) @(posedge clk_i);
    #1;
    checks++;
    if (wdExit !== 64'h1) begin
      errors++;
      $display("[TB] FAIL wd_no_override exit=%h expected 1", wdExit);
    end

    rst_ni = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (48) @(posedge clk_i);
    #1;
    sendWrite(BASE, 64'h9, 8'hFF, 1'b1, 1'b1);
    @(posedge clk_i);
    #1;
    checks++;
    if (wdExit !== 64'h9) begin
      errors++;
      $display("[TB] FAIL wd_tie exit=%h expected 9", wdExit);
    end
    waitB(resp);
    ackB();
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    applyReset();
    sendWrite(BASE, 64'h5, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    checks++;
    if (exit_o !== 64'h5) begin
      errors++;
      $display("[TB] FAIL mid_pre exit=%h expected 5", exit_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (b_valid_o !== 1'b0 || exit_o !== 64'd0 || aw_ready_o !== 1'b0 || b_resp_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_async b_valid=%0b exit=%h aw_ready=%0b resp=%b expected 0/0/0/00",
               b_valid_o, exit_o, aw_ready_o, b_resp_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    sendWrite(BASE, 64'h3, 8'hFF, 1'b1, 1'b1);
    waitB(resp);
    ackB();
    checks++;
    if (exit_o !== 64'h3 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_after exit=%h resp=%b expected 3/00", exit_o, resp);
    end
  endtask

  initial begin
    test_reset();
    test_pass_exit();
    test_split_exit();
    test_strobes();
    test_decode_backpressure();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ara_tohost_ctrl.md
Name: ara_tohost_ctrl

Overview:
- AXI4-Lite subordinate in the Ara test harness that implements the HTIF-style `tohost`/`fromhost` mailbox.
- Produces the 64-bit `exit_o` word that the top-level testbench samples to end simulation: bit0 = done, bits[63:1] = exit code.
- Sits on a harness crossbar port next to the DRAM model; programs running on the core write `tohost` to report pass/fail.
- Includes an optional watchdog that forces a failure exit if the program hangs.

Parameters:
- `AddrWidth`, 64: AXI address width.
- `BaseAddr`, 64'h8000_1000: address of `tohost`; `fromhost` is at `BaseAddr`+8. Must be 16-byte aligned.
- `TimeoutCycles`, 0: watchdog limit in cycles after reset. 0 disables the watchdog.
- `TimeoutCode`, 64'hFFFF: exit code reported on watchdog expiry.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `aw_addr_i`, in, `AddrWidth`; `aw_valid_i`, in, 1; `aw_ready_o`, out, 1: write-address channel.
- `w_data_i`, in, 64; `w_strb_i`, in, 8; `w_valid_i`, in, 1; `w_ready_o`, out, 1: write-data channel.
- `b_resp_o`, out, 2; `b_valid_o`, out, 1; `b_ready_i`, in, 1: write-response channel.
- `ar_addr_i`, in, `AddrWidth`; `ar_valid_i`, in, 1; `ar_ready_o`, out, 1: read-address channel.
- `r_data_o`, out, 64; `r_resp_o`, out, 2; `r_valid_o`, out, 1; `r_ready_i`, in, 1: read-data channel.
- `exit_o`, out, 64: {code[62:0], done}.

Behaviour:
- **Reset values:** all ready/valid outputs 0, resp 0, `r_data_o` 0, `exit_o` 0, `tohost` = `fromhost` = 0, watchdog counter 0. Reset is asynchronous; it aborts any in-flight transaction and drops all pending state.
- **Address decode:** offset = addr − `BaseAddr`. Use addr[2:0] ignored. Offset 0 selects `tohost`, 8 selects `fromhost`. Any other address gives resp SLVERR (2'b10), no register update, read data 0.
- **Write path:**
  - AW and W are captured independently into one-entry holding registers.
  - `aw_ready_o` = AW holder empty and no B pending; `w_ready_o` = W holder empty and no B pending.
  - AW and W may arrive in the same cycle or in either order.
  - The cycle after both holders are full: the register update applies a strobe merge (byte i updated iff `w_strb_i`[i]), both holders clear, and `b_valid_o` asserts.
  - `b_valid_o` holds with a stable resp until `b_ready_i`. No new AW or W is accepted while B is pending.
- **Read path:**
  - `ar_ready_o` = !`r_valid_o`.
  - On the AR handshake, the next cycle drives `r_valid_o` = 1 with the register value and resp. These stay stable until `r_ready_i`.
  - Reads and writes are independent. A read in the same cycle as a write update returns the pre-update value.
- **Exit logic:**
  - When a `tohost` update produces a merged value v with v[0] = 1 and done not yet set, `exit_o` <= v. This is visible in the same cycle `b_valid_o` first asserts.
  - Once done, `exit_o` is sticky until reset. Later `tohost` writes update the register but not `exit_o`.
  - A merged value with v[0] = 0 (syscall/proxy request) only updates the register.
- **Watchdog:**
  - Active only when `TimeoutCycles` ≠ 0.
  - The counter increments every cycle while done = 0 and saturates at `TimeoutCycles`.
  - On reaching `TimeoutCycles`: `exit_o` <= {`TimeoutCode`[62:0], 1'b1} and done = 1.
  - If a program exit and the timeout occur in the same cycle, the program exit wins.
- **Writes to `fromhost`:** update the register only; no side effects.

Test Plan:
- **Passing exit:** write 64'h1 to `BaseAddr` with strb FF → B OKAY 1 cycle after both handshakes; `exit_o` = 64'h1 in that same cycle; stays 1 through 100 idle cycles.
- **Failing exit, split channels:** W (data 64'h7, strb FF) 3 cycles before AW → single B OKAY; `exit_o` = 64'h7 (code 3). A subsequent write of 64'h1 leaves `exit_o` = 64'h7; readback of `tohost` = 64'h1.
- **Byte strobes:** write 64'hAAAA_AAAA_AAAA_AAAA strb FF to `fromhost`, then 64'h5555 strb 8'h03 → readback 64'hAAAA_AAAA_AAAA_5555; `exit_o` stays 0.
- **Decode error and backpressure:** write to `BaseAddr`+16 → SLVERR, no state change. With `b_ready_i` held low 5 cycles: `b_valid_o`/resp stable, `aw_ready_o` = `w_ready_o` = 0 throughout. Read of `BaseAddr`+16 → r resp SLVERR, data 0.
- **Watchdog:** `TimeoutCycles` = 50, no writes → `exit_o` = 64'h1FFFF from cycle 50 after reset release. A second run with write 64'h1 completing at cycle 20 → `exit_o` = 64'h1 with no timeout override.
- **Reset mid-operation:** assert `rst_ni` low while B is pending and after done is set → all outputs 0 immediately (asynchronously). After release, a new write of 64'h3 gives `exit_o` = 64'h3.
